// File: rtl/swc_rtu_req_arbiter.sv
// swc_rtu_req_arbiter: round-robin share of one RTU lookup engine among
// g_num_ports input blocks, one lookup in flight, with a per-port
// valid/ack holding register that feeds swc_core rtu_rsp_* directly.
// Optional: define SWC_RTU_ARB_TIMEOUT_EN to force a drop result when the
// engine stays silent for g_timeout WAIT cycles.

// One port's response holding register.
module swc_rtu_rsp_slot #(
  parameter int g_num_ports  = 7,
  parameter int g_prio_width = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    load,
  input  logic                    ack,
  input  logic [g_num_ports-1:0]  mask_in,
  input  logic                    drop_in,
  input  logic [g_prio_width-1:0] prio_in,
  output logic                    valid,
  output logic [g_num_ports-1:0]  mask,
  output logic                    drop,
  output logic [g_prio_width-1:0] prio
);

  // Load sets valid with fresh fields; ack only clears valid, fields stay.
  // Load and ack cannot coincide: a port with valid set is never granted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid <= 1'b0;
      mask  <= '0;
      drop  <= 1'b0;
      prio  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      mask  <= mask_in;
      drop  <= drop_in;
      prio  <= prio_in;
    end else if (ack && valid) begin
      valid <= 1'b0;
    end
  end

endmodule

module swc_rtu_req_arbiter #(
  parameter int g_num_ports     = 7,
  parameter int g_port_id_width = 3,
  parameter int g_prio_width    = 3,
  parameter int g_timeout       = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [g_num_ports-1:0]              port_req_i,
  output logic [g_num_ports-1:0]              port_req_ack_o,
  output logic                                eng_req_o,
  output logic [g_port_id_width-1:0]          eng_port_o,
  input  logic                                eng_rsp_valid_i,
  input  logic [g_num_ports-1:0]              eng_dst_mask_i,
  input  logic                                eng_drop_i,
  input  logic [g_prio_width-1:0]             eng_prio_i,
  output logic [g_num_ports-1:0]              rtu_rsp_valid_o,
  input  logic [g_num_ports-1:0]              rtu_rsp_ack_i,
  output logic [g_num_ports*g_num_ports-1:0]  rtu_dst_port_mask_o,
  output logic [g_num_ports-1:0]              rtu_drop_o,
  output logic [g_num_ports*g_prio_width-1:0] rtu_prio_o
);

  localparam int N  = g_num_ports;
  localparam int IW = g_port_id_width;
  localparam int PW = g_prio_width;

  if (g_timeout < 1 || (2**IW) < N) begin : g_bad_params
    $error("swc_rtu_req_arbiter: port id width too small or g_timeout < 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  typedef struct packed {
    logic [N-1:0]  mask;
    logic          drop;
    logic [PW-1:0] prio;
  } rsp_t;

  state_t        state;
  logic [IW-1:0] ptr;
  rsp_t          rsp_q;
  logic [N-1:0]  elig;
  logic [N-1:0]  load;
  logic          any_elig;
  logic [IW-1:0] pick;
  int            j;

`ifdef SWC_RTU_ARB_TIMEOUT_EN
  localparam int TW = (g_timeout > 1) ? $clog2(g_timeout + 1) : 1;
  logic [TW-1:0] cnt;
`endif

  // A port holding an unacked response may not start another lookup.
  assign elig = port_req_i & ~rtu_rsp_valid_o;

  // Round-robin search starting one past the last grant, wrapping at N-1.
  always_comb begin
    any_elig = 1'b0;
    pick     = ptr;
    j        = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any_elig && elig[IW'(j)]) begin
        any_elig = 1'b1;
        pick     = IW'(j);
      end
    end
  end

  // Control FSM; eng_port_o doubles as the current grant index.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      ptr            <= IW'(N - 1);
      eng_req_o      <= 1'b0;
      eng_port_o     <= '0;
      port_req_ack_o <= '0;
      rsp_q          <= '0;
`ifdef SWC_RTU_ARB_TIMEOUT_EN
      cnt            <= '0;
`endif
    end else begin
      eng_req_o      <= 1'b0;
      port_req_ack_o <= '0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            ptr            <= pick;
            eng_port_o     <= pick;
            eng_req_o      <= 1'b1;
            port_req_ack_o <= N'(1) << pick;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef SWC_RTU_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          if (eng_rsp_valid_i) begin
            rsp_q.mask <= eng_dst_mask_i;
            rsp_q.drop <= eng_drop_i;
            rsp_q.prio <= eng_prio_i;
            state      <= DELIVER;
          end
`ifdef SWC_RTU_ARB_TIMEOUT_EN
          // Counter reaches g_timeout on this edge: give up with a drop.
          else if (cnt == TW'(g_timeout - 1)) begin
            rsp_q.mask <= '0;
            rsp_q.drop <= 1'b1;
            rsp_q.prio <= '0;
            cnt        <= cnt + TW'(1);
            state      <= DELIVER;
          end else begin
            cnt <= cnt + TW'(1);
          end
`endif
        end
        DELIVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-port holding registers; only the granted port loads, in DELIVER.
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign load[i] = (state == DELIVER) && (eng_port_o == IW'(i));

    swc_rtu_rsp_slot #(
      .g_num_ports  (N),
      .g_prio_width (PW)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load    (load[i]),
      .ack     (rtu_rsp_ack_i[i]),
      .mask_in (rsp_q.mask),
      .drop_in (rsp_q.drop),
      .prio_in (rsp_q.prio),
      .valid   (rtu_rsp_valid_o[i]),
      .mask    (rtu_dst_port_mask_o[i*N +: N]),
      .drop    (rtu_drop_o[i]),
      .prio    (rtu_prio_o[i*PW +: PW])
    );
  end

endmodule

// File: tb/tb_swc_rtu_req_arbiter.sv
// Directed bench for swc_rtu_req_arbiter: cycle table for a single lookup,
// then hand-written fairness, blocking, timeout and reset sequences.
module tb_swc_rtu_req_arbiter;

  localparam int N   = 7;
  localparam int IW  = 3;
  localparam int PW  = 3;
  localparam int TMO = 16;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic [N-1:0]     port_req_i = '0;
  logic [N-1:0]     port_req_ack_o;
  logic             eng_req_o;
  logic [IW-1:0]    eng_port_o;
  logic             eng_rsp_valid_i = 1'b0;
  logic [N-1:0]     eng_dst_mask_i = '0;
  logic             eng_drop_i = 1'b0;
  logic [PW-1:0]    eng_prio_i = '0;
  logic [N-1:0]     rtu_rsp_valid_o;
  logic [N-1:0]     rtu_rsp_ack_i = '0;
  logic [N*N-1:0]   rtu_dst_port_mask_o;
  logic [N-1:0]     rtu_drop_o;
  logic [N*PW-1:0]  rtu_prio_o;

  int checks = 0;
  int failures = 0;

  swc_rtu_req_arbiter #(
    .g_num_ports     (N),
    .g_port_id_width (IW),
    .g_prio_width    (PW),
    .g_timeout       (TMO)
  ) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .port_req_i          (port_req_i),
    .port_req_ack_o      (port_req_ack_o),
    .eng_req_o           (eng_req_o),
    .eng_port_o          (eng_port_o),
    .eng_rsp_valid_i     (eng_rsp_valid_i),
    .eng_dst_mask_i      (eng_dst_mask_i),
    .eng_drop_i          (eng_drop_i),
    .eng_prio_i          (eng_prio_i),
    .rtu_rsp_valid_o     (rtu_rsp_valid_o),
    .rtu_rsp_ack_i       (rtu_rsp_ack_i),
    .rtu_dst_port_mask_o (rtu_dst_port_mask_o),
    .rtu_drop_o          (rtu_drop_o),
    .rtu_prio_o          (rtu_prio_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    ack;
    logic            ev;
    logic [N-1:0]    emask;
    logic [PW-1:0]   eprio;
    logic            er;
    logic [IW-1:0]   ep;
    logic [N-1:0]    rack;
    logic [N-1:0]    vld;
    logic [N*N-1:0]  mbus;
    logic [N*PW-1:0] pbus;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] req, input logic [N-1:0] ack,
                              input logic ev, input logic [N-1:0] emask,
                              input logic [PW-1:0] eprio, input logic er,
                              input logic [IW-1:0] ep, input logic [N-1:0] rack,
                              input logic [N-1:0] vld, input logic [N*N-1:0] mbus,
                              input logic [N*PW-1:0] pbus);
    vec_t v;
    v.req = req; v.ack = ack; v.ev = ev; v.emask = emask; v.eprio = eprio;
    v.er = er; v.ep = ep; v.rack = rack; v.vld = vld; v.mbus = mbus; v.pbus = pbus;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    port_req_i = '0;
    rtu_rsp_ack_i = '0;
    eng_rsp_valid_i = 1'b0;
    eng_dst_mask_i = '0;
    eng_drop_i = 1'b0;
    eng_prio_i = '0;
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_eng_req"},  64'(eng_req_o), 64'd0);
    chk({tag, "_eng_port"}, 64'(eng_port_o), 64'd0);
    chk({tag, "_req_ack"},  64'(port_req_ack_o), 64'd0);
    chk({tag, "_valid"},    64'(rtu_rsp_valid_o), 64'd0);
    chk({tag, "_mask"},     64'(rtu_dst_port_mask_o), 64'd0);
    chk({tag, "_drop"},     64'(rtu_drop_o), 64'd0);
    chk({tag, "_prio"},     64'(rtu_prio_o), 64'd0);
  endtask

  // Wait (bounded) for the ISSUE cycle and check it targets port p.
  task automatic wait_grant(input int p, input bit drop_req);
    bit got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (!got) begin
        if (eng_req_o) got = 1'b1;
        else tick();
      end
    end
    chk("grant_seen", 64'(got), 64'd1);
    chk("grant_port", 64'(eng_port_o), 64'(p));
    chk("grant_req_ack", 64'(port_req_ack_o), 64'd1 << p);
    if (drop_req) port_req_i[p] = 1'b0;
  endtask

  // Full lookup for port p; engine answers lat cycles after ISSUE.
  task automatic serve(input int p, input bit drop_req, input int lat,
                       input logic [N-1:0] m, input logic [PW-1:0] pr);
    wait_grant(p, drop_req);
    repeat (lat) tick();
    eng_rsp_valid_i = 1'b1;
    eng_dst_mask_i = m;
    eng_prio_i = pr;
    tick();
    eng_rsp_valid_i = 1'b0;
    eng_dst_mask_i = '0;
    eng_prio_i = '0;
    chk("deliver_not_yet", 64'(rtu_rsp_valid_o[p]), 64'd0);
    tick();
    chk("rsp_valid", 64'(rtu_rsp_valid_o[p]), 64'd1);
    chk("rsp_mask", 64'(rtu_dst_port_mask_o[p*N +: N]), 64'(m));
    chk("rsp_prio", 64'(rtu_prio_o[p*PW +: PW]), 64'(pr));
    chk("rsp_drop", 64'(rtu_drop_o[p]), 64'd0);
  endtask

  initial begin
    vec_t vt[10];
    int   ackcnt[N];
    bit   prev;
    int   n;
    int   last;
    int   pulses;

    // Single lookup for port 2, engine answers 3 cycles after eng_req_o.
    vt[0] = mk(7'h04, 7'h00, 1'b0, 7'h00, 3'd0, 1'b1, 3'd2, 7'h04, 7'h00, 49'h0, 21'h0);
    vt[1] = mk(7'h00, 7'h00, 1'b0, 7'h00, 3'd0, 1'b0, 3'd2, 7'h00, 7'h00, 49'h0, 21'h0);
    vt[2] = mk(7'h00, 7'h00, 1'b0, 7'h00, 3'd0, 1'b0, 3'd2, 7'h00, 7'h00, 49'h0, 21'h0);
    vt[3] = mk(7'h00, 7'h00, 1'b0, 7'h00, 3'd0, 1'b0, 3'd2, 7'h00, 7'h00, 49'h0, 21'h0);
    vt[4] = mk(7'h00, 7'h00, 1'b1, 7'h05, 3'd5, 1'b0, 3'd2, 7'h00, 7'h00, 49'h0, 21'h0);
    vt[5] = mk(7'h00, 7'h00, 1'b0, 7'h00, 3'd0, 1'b0, 3'd2, 7'h00, 7'h04, 49'h14000, 21'h140);
    vt[6] = mk(7'h00, 7'h00, 1'b0, 7'h00, 3'd0, 1'b0, 3'd2, 7'h00, 7'h04, 49'h14000, 21'h140);
    vt[7] = mk(7'h00, 7'h04, 1'b0, 7'h00, 3'd0, 1'b0, 3'd2, 7'h00, 7'h00, 49'h14000, 21'h140);
    vt[8] = mk(7'h00, 7'h04, 1'b0, 7'h00, 3'd0, 1'b0, 3'd2, 7'h00, 7'h00, 49'h14000, 21'h140);
    vt[9] = mk(7'h04, 7'h00, 1'b0, 7'h00, 3'd0, 1'b1, 3'd2, 7'h04, 7'h00, 49'h14000, 21'h140);

    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 10; i++) begin
      port_req_i      = vt[i].req;
      rtu_rsp_ack_i   = vt[i].ack;
      eng_rsp_valid_i = vt[i].ev;
      eng_dst_mask_i  = vt[i].emask;
      eng_prio_i      = vt[i].eprio;
      eng_drop_i      = 1'b0;
      tick();
      chk($sformatf("vec%0d_eng_req", i),  64'(eng_req_o), 64'(vt[i].er));
      chk($sformatf("vec%0d_eng_port", i), 64'(eng_port_o), 64'(vt[i].ep));
      chk($sformatf("vec%0d_req_ack", i),  64'(port_req_ack_o), 64'(vt[i].rack));
      chk($sformatf("vec%0d_valid", i),    64'(rtu_rsp_valid_o), 64'(vt[i].vld));
      chk($sformatf("vec%0d_mask", i),     64'(rtu_dst_port_mask_o), 64'(vt[i].mbus));
      chk($sformatf("vec%0d_prio", i),     64'(rtu_prio_o), 64'(vt[i].pbus));
    end

    // Fairness: all ports at once, immediate engine answer and acks.
    do_reset();
    foreach (ackcnt[i]) ackcnt[i] = 0;
    prev = 1'b0;
    n = 0;
    last = 0;
    port_req_i = '1;
    for (int c = 0; c < 40; c++) begin
      eng_rsp_valid_i = prev;
      eng_dst_mask_i  = prev ? 7'h7F : 7'h00;
      rtu_rsp_ack_i   = rtu_rsp_valid_o;
      for (int i = 0; i < N; i++)
        if (port_req_ack_o[i]) begin
          ackcnt[i]++;
          port_req_i[i] = 1'b0;
        end
      if (eng_req_o) begin
        chk("fair_order", 64'(eng_port_o), 64'(n));
        chk("fair_req_ack", 64'(port_req_ack_o), 64'd1 << n);
        if (n > 0) chk("fair_spacing", 64'(c - last), 64'd4);
        last = c;
        n++;
      end
      prev = eng_req_o;
      tick();
    end
    rtu_rsp_ack_i = '0;
    eng_rsp_valid_i = 1'b0;
    chk("fair_grants", 64'(n), 64'd7);
    for (int i = 0; i < N; i++) chk($sformatf("fair_ack_port%0d", i), 64'(ackcnt[i]), 64'd1);
    chk("fair_all_acked", 64'(rtu_rsp_valid_o), 64'd0);

    // Blocking: port 1 holds an unacked response and keeps requesting.
    do_reset();
    port_req_i = 7'h02;
    serve(1, 1'b0, 2, 7'h11, 3'd1);
    port_req_i = 7'h0A;
    serve(3, 1'b1, 1, 7'h22, 3'd3);
    pulses = 0;
    repeat (4) begin
      if (eng_req_o) pulses++;
      tick();
    end
    chk("block_no_regrant", 64'(pulses), 64'd0);
    chk("block_port1_held", 64'(rtu_dst_port_mask_o[1*N +: N]), 64'h11);
    rtu_rsp_ack_i = 7'h0A;
    tick();
    rtu_rsp_ack_i = '0;
    chk("block_acked", 64'(rtu_rsp_valid_o), 64'd0);
    serve(1, 1'b1, 1, 7'h44, 3'd6);

`ifdef SWC_RTU_ARB_TIMEOUT_EN
    // Timeout: preload port 4 with non-zero fields, then let the engine idle.
    do_reset();
    port_req_i = 7'h10;
    serve(4, 1'b1, 1, 7'h7F, 3'd7);
    rtu_rsp_ack_i = 7'h10;
    tick();
    rtu_rsp_ack_i = '0;
    port_req_i = 7'h10;
    wait_grant(4, 1'b1);
    repeat (17) tick();
    chk("tmo_early", 64'(rtu_rsp_valid_o[4]), 64'd0);
    tick();
    chk("tmo_valid", 64'(rtu_rsp_valid_o[4]), 64'd1);
    chk("tmo_drop", 64'(rtu_drop_o[4]), 64'd1);
    chk("tmo_mask", 64'(rtu_dst_port_mask_o[4*N +: N]), 64'd0);
    chk("tmo_prio", 64'(rtu_prio_o[4*PW +: PW]), 64'd0);
    eng_rsp_valid_i = 1'b1;
    eng_dst_mask_i = 7'h7F;
    eng_prio_i = 3'd7;
    tick();
    eng_rsp_valid_i = 1'b0;
    eng_dst_mask_i = '0;
    eng_prio_i = '0;
    repeat (2) tick();
    chk("late_valid", 64'(rtu_rsp_valid_o), 64'h10);
    chk("late_drop", 64'(rtu_drop_o[4]), 64'd1);
    chk("late_mask", 64'(rtu_dst_port_mask_o[4*N +: N]), 64'd0);
    chk("late_prio", 64'(rtu_prio_o[4*PW +: PW]), 64'd0);
`else
    // Without the timeout, WAIT holds until the engine answers.
    do_reset();
    port_req_i = 7'h10;
    wait_grant(4, 1'b1);
    repeat (40) tick();
    chk("no_tmo_valid", 64'(rtu_rsp_valid_o), 64'd0);
    eng_rsp_valid_i = 1'b1;
    eng_dst_mask_i = 7'h03;
    tick();
    eng_rsp_valid_i = 1'b0;
    eng_dst_mask_i = '0;
    tick();
    chk("no_tmo_deliver", 64'(rtu_rsp_valid_o), 64'h10);
    chk("no_tmo_drop", 64'(rtu_drop_o[4]), 64'd0);
    chk("no_tmo_mask", 64'(rtu_dst_port_mask_o[4*N +: N]), 64'h03);
`endif

    // Spurious engine strobe in IDLE, then reset in the middle of WAIT.
    do_reset();
    eng_rsp_valid_i = 1'b1;
    eng_dst_mask_i = 7'h7F;
    eng_drop_i = 1'b1;
    tick();
    eng_rsp_valid_i = 1'b0;
    eng_dst_mask_i = '0;
    eng_drop_i = 1'b0;
    repeat (2) tick();
    chk("spur_valid", 64'(rtu_rsp_valid_o), 64'd0);
    chk("spur_drop", 64'(rtu_drop_o), 64'd0);
    chk("spur_eng_req", 64'(eng_req_o), 64'd0);
    port_req_i = 7'h20;
    wait_grant(5, 1'b0);
    repeat (2) tick();
    port_req_i = 7'h60;
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    rst_n_i = 1'b1;
    serve(5, 1'b1, 1, 7'h09, 3'd2);
    serve(6, 1'b1, 1, 7'h0C, 3'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swc_rtu_req_arbiter.md
Name: swc_rtu_req_arbiter

Overview:
Shares a single RTU lookup engine among the g_num_ports switch input blocks. Requests are served round-robin with at most one lookup in flight. Each engine result is returned to the requesting port through a per-port valid/ack holding register, which feeds the swc_core rtu_rsp_* inputs directly. The block sits between the endpoints' header parsers, the RTU engine and swc_core.

Parameters:
g_num_ports, 7, number of switch ports; also the destination mask width
g_port_id_width, 3, width of eng_port_o; must satisfy 2**g_port_id_width >= g_num_ports
g_prio_width, 3, width of the priority field
g_timeout, 255, WAIT-state cycles before forced drop (only with the timeout feature compiled in)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset; asynchronous, active-low
port_req_i  in  g_num_ports  per-port lookup request; level, held by the requester until acked
port_req_ack_o  out  g_num_ports  one-cycle pulse: request accepted and issued to the engine
eng_req_o  out  1  one-cycle lookup strobe to the engine
eng_port_o  out  g_port_id_width  index of the granted port; valid while eng_req_o=1
eng_rsp_valid_i  in  1  engine result strobe, one cycle
eng_dst_mask_i  in  g_num_ports  engine destination mask
eng_drop_i  in  1  engine drop decision
eng_prio_i  in  g_prio_width  engine priority
rtu_rsp_valid_o  out  g_num_ports  per-port response valid
rtu_rsp_ack_i  in  g_num_ports  per-port response acknowledge
rtu_dst_port_mask_o  out  g_num_ports*g_num_ports  port i mask at bits [(i+1)*g_num_ports-1 : i*g_num_ports]
rtu_drop_o  out  g_num_ports  per-port drop
rtu_prio_o  out  g_num_ports*g_prio_width  port i priority at bits [(i+1)*g_prio_width-1 : i*g_prio_width]

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - all outputs 0; FSM=IDLE; RR pointer = g_num_ports-1, so port 0 has first priority.
  - all response registers cleared; timeout counter cleared.
- Eligibility: port i is eligible when port_req_i[i]=1 and registered rtu_rsp_valid_o[i]=0. A port acking in cycle t becomes eligible in cycle t+1.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - If any port is eligible, grant the first eligible port searching from pointer+1 upward, wrapping at g_num_ports-1 to 0.
  - Register the grant index g, set pointer=g, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): eng_req_o=1, eng_port_o=g, port_req_ack_o[g]=1; then go to WAIT with the timeout counter at 0.
- WAIT:
  - On eng_rsp_valid_i=1, latch mask/drop/prio and go to DELIVER.
  - eng_rsp_valid_i in any other state is ignored.
- DELIVER (1 cycle):
  - Load port g's mask/drop/prio registers and set rtu_rsp_valid_o[g]=1 on the same edge.
  - Result is visible 2 cycles after eng_rsp_valid_i.
  - Return to IDLE.
- Minimum grant-to-grant spacing: 4 cycles (IDLE, ISSUE, WAIT with immediate response, DELIVER).
- Response hold: rtu_rsp_valid_o[i] and its fields stay stable until rtu_rsp_ack_i[i]=1 is sampled; valid clears on the next edge and the fields keep their values.
  - An ack while valid=0 is ignored.
  - The port-g load in DELIVER cannot collide with an ack, because g was not eligible while its valid was set.
- Multiple ports may hold valid responses concurrently. Acks are independent per port.
- eng_port_o holds the last grant index outside ISSUE. eng_req_o is never asserted outside ISSUE.
- Reset mid-operation: state is abandoned with no response delivered. A requester still holding port_req_i is re-arbitrated after reset.

Optional Feature:
SWC_RTU_ARB_TIMEOUT_EN
- Defined:
  - The timeout counter increments every WAIT cycle.
  - When it reaches g_timeout with no eng_rsp_valid_i, go to DELIVER with drop=1, mask=0, prio=0.
  - If eng_rsp_valid_i arrives in the same cycle the counter reaches g_timeout, the engine result wins.
  - A late engine response arriving in a later state is ignored.
- Undefined: no counter; WAIT persists until eng_rsp_valid_i; g_timeout is unused.

Test Plan:
- Single request: port_req_i[2]=1 from cycle 0; engine answers 3 cycles after eng_req_o with mask 0x05, drop=0, prio=5 -> port_req_ack_o[2] and eng_req_o pulse together with eng_port_o=2; rtu_rsp_valid_o[2]=1 two cycles after eng_rsp_valid_i; mask slice = 0x05, prio slice = 5; valid drops one cycle after ack.
- Fairness: all 7 ports request simultaneously; engine answers in the first WAIT cycle; responses acked immediately -> grants in order 0,1,...,6, one per 4 cycles; each port acked exactly once.
- Blocking: port 1 holds an unacked response and re-requests while port 3 also requests -> port 3 granted, port 1 not; ack port 1 -> port 1 granted next.
- Timeout (macro defined, g_timeout=16): engine silent after grant of port 4 -> after 16 WAIT cycles, rtu_rsp_valid_o[4]=1 with drop=1, mask=0, prio=0; a later eng_rsp_valid_i is ignored.
- Spurious and reset: eng_rsp_valid_i pulsed in IDLE -> no valid set. rst_n_i asserted mid-WAIT -> all outputs 0 immediately; after release, the pending port_req_i[5] is granted first (pointer reset).
